ic_mem_arbiter_2to1: RTL and testbench

Two-requester, one-target arbiter on the SoC CPU memory bus (req/gnt request channel, recv/ack response channel). It lets the CPU instruction port (m0) and data port (m1) share a single memory target, e.g. one BRAM bus bridge. Request ownership is tracked in an in-order ID FIFO, and each response is routed back to the requester that issued it. It sits between the interconnect and a shared-memory bus bridge.

---
 rtl/ic_mem_arbiter_2to1.sv | 158 +++++++++++++++
 tb/tb_ic_mem_arbiter_2to1.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ic_mem_arbiter_2to1.sv
// Two-requester memory bus arbiter with an in-order ID FIFO for response routing.
// Define IC_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed m0 priority.
module ic_mem_arbiter_2to1 #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          g_clk,
  input  logic          g_reset,
  input  logic          m0_req,
  input  logic          m0_wen,
  input  logic [3:0]    m0_strb,
  input  logic [31:0]   m0_wdata,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_gnt,
  output logic          m0_recv,
  input  logic          m0_ack,
  output logic          m0_error,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wen,
  input  logic [3:0]    m1_strb,
  input  logic [31:0]   m1_wdata,
  input  logic [AW-1:0] m1_addr,
  output logic          m1_gnt,
  output logic          m1_recv,
  input  logic          m1_ack,
  output logic          m1_error,
  output logic [31:0]   m1_rdata,
  output logic          s_req,
  output logic          s_wen,
  output logic [3:0]    s_strb,
  output logic [31:0]   s_wdata,
  output logic [AW-1:0] s_addr,
  input  logic          s_gnt,
  input  logic          s_recv,
  output logic          s_ack,
  input  logic          s_error,
  input  logic [31:0]   s_rdata,
  output logic          proto_err
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  logic sel_q;
  logic locked_q;
  logic cur_sel;
  logic tie_pick;
  logic xfer;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic head;

  logic [DEPTH-1:0] id_mem;
  ptr_t wptr;
  ptr_t rptr;
  cnt_t count;

`ifdef IC_ARB_ROUND_ROBIN_EN
  logic last_q;

  assign tie_pick = ~last_q;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      last_q <= 1'b1;
    end else if (xfer) begin
      last_q <= cur_sel;
    end
  end
`else
  assign tie_pick = 1'b0;
`endif

  // Owner is frozen while a request is waiting on s_gnt.
  always_comb begin
    cur_sel = sel_q;
    if (locked_q) begin
      cur_sel = sel_q;
    end else if (m0_req && m1_req) begin
      cur_sel = tie_pick;
    end else if (m1_req) begin
      cur_sel = 1'b1;
    end else if (m0_req) begin
      cur_sel = 1'b0;
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = id_mem[rptr];

  assign s_req   = (cur_sel ? m1_req : m0_req) && !full;
  assign s_wen   = cur_sel ? m1_wen   : m0_wen;
  assign s_strb  = cur_sel ? m1_strb  : m0_strb;
  assign s_wdata = cur_sel ? m1_wdata : m0_wdata;
  assign s_addr  = cur_sel ? m1_addr  : m0_addr;

  assign xfer   = s_req && s_gnt;
  assign m0_gnt = xfer && !cur_sel;
  assign m1_gnt = xfer && cur_sel;

  // Responses with nothing outstanding are swallowed.
  assign s_ack   = empty ? 1'b1 : (head ? m1_ack : m0_ack);
  assign m0_recv = s_recv && !empty && !head;
  assign m1_recv = s_recv && !empty && head;

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_error = s_error;
  assign m1_error = s_error;

  assign push = xfer;
  assign pop  = s_recv && s_ack && !empty;

  always_ff @(posedge g_clk) begin
    if (push) begin
      id_mem[wptr] <= cur_sel;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      sel_q     <= 1'b0;
      locked_q  <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      sel_q    <= cur_sel;
      locked_q <= s_req && !s_gnt;
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (s_recv && empty) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ic_mem_arbiter_2to1.sv
// Directed bench for ic_mem_arbiter_2to1 (DEPTH=2).
// Tie expectations follow IC_ARB_ROUND_ROBIN_EN when defined.
module tb_ic_mem_arbiter_2to1;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        m0_req, m0_wen, m0_gnt, m0_recv, m0_ack, m0_error;
  logic [3:0]  m0_strb;
  logic [31:0] m0_wdata, m0_addr, m0_rdata;
  logic        m1_req, m1_wen, m1_gnt, m1_recv, m1_ack, m1_error;
  logic [3:0]  m1_strb;
  logic [31:0] m1_wdata, m1_addr, m1_rdata;
  logic        s_req, s_wen, s_gnt, s_recv, s_ack, s_error;
  logic [3:0]  s_strb;
  logic [31:0] s_wdata, s_addr, s_rdata;
  logic        proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 g_clk = ~g_clk;

  ic_mem_arbiter_2to1 #(.DEPTH(2), .AW(32)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_strb(m0_strb),
    .m0_wdata(m0_wdata), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_recv(m0_recv), .m0_ack(m0_ack), .m0_error(m0_error),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_strb(m1_strb),
    .m1_wdata(m1_wdata), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
    .m1_recv(m1_recv), .m1_ack(m1_ack), .m1_error(m1_error),
    .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wen(s_wen), .s_strb(s_strb),
    .s_wdata(s_wdata), .s_addr(s_addr), .s_gnt(s_gnt),
    .s_recv(s_recv), .s_ack(s_ack), .s_error(s_error),
    .s_rdata(s_rdata), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r0, input logic r1, input logic sg,
                      input logic sr, input logic k0, input logic k1);
    @(negedge g_clk);
    m0_req = r0;
    m1_req = r1;
    s_gnt  = sg;
    s_recv = sr;
    m0_ack = k0;
    m1_ack = k1;
    #1;
  endtask

  logic tie1;

  initial begin
`ifdef IC_ARB_ROUND_ROBIN_EN
    tie1 = 1'b1;
`else
    tie1 = 1'b0;
`endif
    g_reset = 1'b1;
    m0_req = 0; m0_wen = 0; m0_strb = 4'hF; m0_wdata = 32'h0;
    m0_addr = 32'h1000_0000; m0_ack = 0;
    m1_req = 0; m1_wen = 1; m1_strb = 4'h3; m1_wdata = 32'h5555_0000;
    m1_addr = 32'h2000_0010; m1_ack = 0;
    s_gnt = 0; s_recv = 0; s_error = 0; s_rdata = 32'h0;
    repeat (2) @(posedge g_clk);

    // reset state
    @(negedge g_clk);
    g_reset = 1'b0;
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_m0_recv", m0_recv, 0);
    chk("rst_m1_recv", m1_recv, 0);
    chk("rst_s_req", s_req, 0);
    chk("rst_perr", proto_err, 0);

    // tie arbitration, then full stops grants
    step(1, 1, 1, 0, 0, 0);
    chk("tie0_m0_gnt", m0_gnt, 1);
    chk("tie0_m1_gnt", m1_gnt, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("tie1_m0_gnt", m0_gnt, !tie1);
    chk("tie1_m1_gnt", m1_gnt, tie1);
    chk("tie1_s_addr", s_addr, tie1 ? 32'h2000_0010 : 32'h1000_0000);
    step(1, 1, 1, 0, 0, 0);
    chk("full_s_req", s_req, 0);
    chk("full_m0_gnt", m0_gnt, 0);
    chk("full_m1_gnt", m1_gnt, 0);
    step(0, 0, 0, 1, 1, 1);
    chk("drn0_m0_recv", m0_recv, 1);
    chk("drn0_m1_recv", m1_recv, 0);
    step(0, 0, 0, 1, 1, 1);
    chk("drn1_m0_recv", m0_recv, !tie1);
    chk("drn1_m1_recv", m1_recv, tie1);

    // lock: m1 stalled, m0 arrives mid-request
    step(0, 1, 0, 0, 0, 0);
    chk("lk1_s_req", s_req, 1);
    chk("lk1_s_addr", s_addr, 32'h2000_0010);
    chk("lk1_s_wen", s_wen, 1);
    chk("lk1_m1_gnt", m1_gnt, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("lk2_s_addr", s_addr, 32'h2000_0010);
    chk("lk2_m0_gnt", m0_gnt, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("lk3_s_strb", s_strb, 4'h3);
    chk("lk3_m0_gnt", m0_gnt, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("lk4_m1_gnt", m1_gnt, 1);
    chk("lk4_m0_gnt", m0_gnt, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("lk5_m0_gnt", m0_gnt, 1);
    chk("lk5_s_addr", s_addr, 32'h1000_0000);
    step(0, 0, 0, 1, 1, 1);
    chk("lkd0_m1_recv", m1_recv, 1);
    chk("lkd0_m0_recv", m0_recv, 0);
    step(0, 0, 0, 1, 1, 1);
    chk("lkd1_m0_recv", m0_recv, 1);

    // in-order routing with ack stall
    step(1, 0, 1, 0, 0, 0);
    chk("rd_m0_gnt", m0_gnt, 1);
    step(0, 1, 1, 0, 0, 0);
    chk("rd_m1_gnt", m1_gnt, 1);
    s_rdata = 32'hAAAA_0000;
    s_error = 1'b1;
    step(0, 0, 0, 1, 0, 1);
    chk("st0_m0_recv", m0_recv, 1);
    chk("st0_m1_recv", m1_recv, 0);
    chk("st0_s_ack", s_ack, 0);
    chk("st0_m0_rdata", m0_rdata, 32'hAAAA_0000);
    chk("st0_m0_error", m0_error, 1);
    step(0, 0, 0, 1, 0, 1);
    chk("st1_s_ack", s_ack, 0);
    chk("st1_m0_recv", m0_recv, 1);
    step(0, 0, 0, 1, 1, 0);
    chk("st2_s_ack", s_ack, 1);
    s_rdata = 32'hBBBB_0000;
    s_error = 1'b0;
    step(0, 0, 0, 1, 0, 1);
    chk("r1_m1_recv", m1_recv, 1);
    chk("r1_m0_recv", m0_recv, 0);
    chk("r1_m1_rdata", m1_rdata, 32'hBBBB_0000);
    chk("r1_s_ack", s_ack, 1);

    // full with simultaneous pop: no bypass
    step(1, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("fp_pre_m1_gnt", m1_gnt, 1);
    step(1, 0, 1, 1, 1, 1);
    chk("fp_s_req", s_req, 0);
    chk("fp_m0_gnt", m0_gnt, 0);
    chk("fp_m0_recv", m0_recv, 1);
    chk("fp_s_ack", s_ack, 1);
    step(1, 0, 1, 0, 0, 0);
    chk("fp_next_m0_gnt", m0_gnt, 1);
    step(0, 0, 0, 1, 1, 1);
    chk("fpd0_m1_recv", m1_recv, 1);
    step(0, 0, 0, 1, 1, 1);
    chk("fpd1_m0_recv", m0_recv, 1);

    // stray response on empty FIFO
    step(0, 0, 0, 1, 0, 0);
    chk("pe_s_ack", s_ack, 1);
    chk("pe_m0_recv", m0_recv, 0);
    chk("pe_m1_recv", m1_recv, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pe_set", proto_err, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("pe_sticky", proto_err, 1);

    // reset with one outstanding
    step(1, 0, 1, 0, 0, 0);
    chk("ro_m0_gnt", m0_gnt, 1);
    @(negedge g_clk);
    m0_req = 0; s_gnt = 0;
    g_reset = 1'b1;
    @(negedge g_clk);
    g_reset = 1'b0;
    #1;
    chk("ro_s_req", s_req, 0);
    chk("ro_perr", proto_err, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("ro_empty_m0_recv", m0_recv, 0);
    chk("ro_empty_s_ack", s_ack, 1);
    step(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
